// File: rtl/drawbridge_pkg.sv
// drawbridge_pkg
// Shared types and default parameter values for the drawbridge controller.
//   bridge_state_t     : controller state encoding
//   DEF_*              : default values for the four top-level parameters
//   is_travel()        : true for the two motor-driven states
package drawbridge_pkg;

  typedef enum logic [2:0] {
    S_FLAT     = 3'd0,
    S_CLEARING = 3'd1,
    S_LIFTING  = 3'd2,
    S_UPRIGHT  = 3'd3,
    S_LOWERING = 3'd4,
    S_FAULT    = 3'd5
  } bridge_state_t;

  localparam int DEF_LANES         = 2;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_CLEAR_DELAY   = 16;
  localparam int DEF_MOTOR_TIMEOUT = 1000;

  function automatic logic is_travel(input bridge_state_t s);
    return (s == S_LIFTING) || (s == S_LOWERING);
  endfunction

endpackage

// File: rtl/drawbridge_ctrl_lane_car_counter.sv
// lane_car_counter
// Saturating count of vehicles on the deck, fed by per-lane entry/exit pulses.
//   Clk        in            system clock, rising edge
//   Reset      in            synchronous, active-low reset
//   i_car_in   in  [LANES]   per-lane entry pulse
//   i_car_out  in  [LANES]   per-lane exit pulse
//   o_count    out [CNT_W]   registered vehicle count
//   o_clamp    out           combinational: this cycle's update hits a clamp
//                            (the parent registers it into its alarm output)
module lane_car_counter
  import drawbridge_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [LANES-1:0] i_car_in,
  input  logic [LANES-1:0] i_car_out,
  output logic [CNT_W-1:0] o_count,
  output logic             o_clamp
);

  // Two extra bits: one for sign, one for headroom above the maximum count.
  localparam int SW = CNT_W + 2;
  localparam logic signed [SW-1:0] MAX_CNT = {2'b00, {CNT_W{1'b1}}};

  logic [CNT_W-1:0]     r_count;
  logic signed [SW-1:0] w_pc_in;
  logic signed [SW-1:0] w_pc_out;
  logic signed [SW-1:0] w_sum;
  logic [CNT_W-1:0]     w_count_next;
  logic                 w_clamp;

  always_comb begin
    w_pc_in  = '0;
    w_pc_out = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pc_in  = w_pc_in  + {{(SW-1){1'b0}}, i_car_in[i]};
      w_pc_out = w_pc_out + {{(SW-1){1'b0}}, i_car_out[i]};
    end
  end

  // Entry and exit on the same lane in one cycle cancel naturally here.
  assign w_sum = $signed({2'b00, r_count}) + w_pc_in - w_pc_out;

  always_comb begin
    w_count_next = w_sum[CNT_W-1:0];
    w_clamp      = 1'b0;
    if (w_sum[SW-1]) begin
      w_count_next = '0;
      w_clamp      = 1'b1;
    end else if (w_sum > MAX_CNT) begin
      w_count_next = {CNT_W{1'b1}};
      w_clamp      = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count = r_count;
  assign o_clamp = w_clamp;

endmodule

// File: rtl/drawbridge_ctrl.sv
// drawbridge_ctrl
// Drawbridge controller: deck vehicle tracking, traffic light, bidirectional
// deck motor between limit switches, clear-deck delay, motor timeout and a
// latched fault. All outputs are registered.
//   Clk       in           system clock, rising edge
//   Reset     in           synchronous, active-low reset
//   CarIn     in  [LANES]  per-lane entry pulse
//   CarOut    in  [LANES]  per-lane exit pulse
//   MD        in           0 = auto (request from BS), 1 = manual (from PB)
//   PB        in           operator lift request (level)
//   BS        in           boat sensor (level)
//   H / L     in           deck-up / deck-down limit switches
//   MT        out          motor enable
//   DIR       out          motor direction, 1 = up
//   AL        out          alarm
//   TFL       out          traffic light, 1 = red
//   CarCount  out [CNT_W]  vehicles on deck
//   Fault     out          latched fault
module drawbridge_ctrl
  import drawbridge_pkg::*;
#(
  parameter int LANES         = DEF_LANES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int CLEAR_DELAY   = DEF_CLEAR_DELAY,
  parameter int MOTOR_TIMEOUT = DEF_MOTOR_TIMEOUT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [LANES-1:0] CarIn,
  input  logic [LANES-1:0] CarOut,
  input  logic             MD,
  input  logic             PB,
  input  logic             BS,
  input  logic             H,
  input  logic             L,
  output logic             MT,
  output logic             DIR,
  output logic             AL,
  output logic             TFL,
  output logic [CNT_W-1:0] CarCount,
  output logic             Fault
);

  localparam int MT_W = $clog2(MOTOR_TIMEOUT + 1);
  localparam int CT_W = $clog2(CLEAR_DELAY + 1);

  bridge_state_t r_state;
  bridge_state_t w_state_next;
  logic [MT_W-1:0] r_mtimer;
  logic [MT_W-1:0] w_mtimer_next;
  logic [CT_W-1:0] r_ctimer;
  logic [CT_W-1:0] w_ctimer_next;
  logic r_mt, r_dir, r_al, r_tfl, r_fault;
  logic w_mt_next, w_dir_next, w_al_next, w_tfl_next, w_fault_next;

  logic [CNT_W-1:0] w_count;
  logic             w_clamp;
  logic             w_req;
  logic             w_empty;
  logic             w_activity;
  logic [MT_W:0]    w_elapsed;
  logic             w_timeout;

  lane_car_counter #(
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) u_counter (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_car_in  (CarIn),
    .i_car_out (CarOut),
    .o_count   (w_count),
    .o_clamp   (w_clamp)
  );

  assign w_req      = MD ? PB : BS;
  assign w_empty    = (w_count == '0) && (CarIn == '0);
  assign w_activity = (|CarIn) || (|CarOut);

  // The motor timer counts cycles in which the motor was actually driven:
  // the registered MT says whether the cycle now ending was a running one,
  // so a paused cycle leaves the count untouched.
  assign w_elapsed = {1'b0, r_mtimer} + {{MT_W{1'b0}}, r_mt};
  assign w_timeout = (w_elapsed == (MT_W+1)'(MOTOR_TIMEOUT));

  always_comb begin
    w_state_next  = r_state;
    w_ctimer_next = '0;
    w_mtimer_next = r_mtimer;
    case (r_state)
      S_FLAT: begin
        w_mtimer_next = '0;
        if (w_req && L) begin
          w_state_next = S_CLEARING;
        end else if (!L) begin
          w_state_next = S_FAULT;
        end
      end
      S_CLEARING: begin
        w_mtimer_next = '0;
        if (!w_req) begin
          w_state_next = S_FLAT;
        end else if (!w_empty) begin
          w_ctimer_next = '0;
        end else if (r_ctimer == CT_W'(CLEAR_DELAY - 1)) begin
          w_state_next = S_LIFTING;
        end else begin
          w_ctimer_next = r_ctimer + 1'b1;
        end
      end
      S_LIFTING: begin
        w_mtimer_next = w_elapsed[MT_W-1:0];
        if (H) begin
          w_state_next  = S_UPRIGHT;
          w_mtimer_next = '0;
        end else if (w_timeout) begin
          w_state_next = S_FAULT;
        end
      end
      S_UPRIGHT: begin
        w_mtimer_next = '0;
        if (!w_req) begin
          w_state_next = S_LOWERING;
        end else if (!H) begin
          w_state_next = S_FAULT;
        end
      end
      S_LOWERING: begin
        w_mtimer_next = w_elapsed[MT_W-1:0];
        if (L) begin
          w_state_next  = S_FLAT;
          w_mtimer_next = '0;
        end else if (w_req) begin
          // A boat arriving while the deck comes down reverses it with a
          // fresh travel budget.
          w_state_next  = S_LIFTING;
          w_mtimer_next = '0;
        end else if (w_timeout) begin
          w_state_next = S_FAULT;
        end
      end
      S_FAULT: begin
        w_state_next = S_FAULT;
      end
      default: begin
        w_state_next = S_FAULT;
      end
    endcase

    // Both limit switches at once means a broken sensor or deck: stop.
    if (H && L) begin
      w_state_next = S_FAULT;
    end
    if (w_state_next != S_CLEARING) begin
      w_ctimer_next = '0;
    end
    if (w_state_next == S_FAULT) begin
      w_mtimer_next = '0;
    end
  end

  // Output values are derived from the state being entered so that the
  // registered outputs line up with the registered state.
  always_comb begin
    w_mt_next    = 1'b0;
    w_dir_next   = 1'b0;
    w_al_next    = w_clamp;
    w_tfl_next   = 1'b1;
    w_fault_next = 1'b0;
    if (is_travel(w_state_next)) begin
      // Vehicles still on (or entering) the deck pause travel.
      w_mt_next = w_empty;
      if (!w_empty) begin
        w_al_next = 1'b1;
      end
    end
    case (w_state_next)
      S_FLAT:    w_tfl_next = 1'b0;
      S_LIFTING: w_dir_next = 1'b1;
      S_FAULT: begin
        w_al_next    = 1'b1;
        w_fault_next = 1'b1;
      end
      default: ;
    endcase
    if ((r_state == S_UPRIGHT) && w_activity) begin
      w_al_next = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state  <= S_FLAT;
      r_mtimer <= '0;
      r_ctimer <= '0;
      r_mt     <= 1'b0;
      r_dir    <= 1'b0;
      r_al     <= 1'b0;
      r_tfl    <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_mtimer <= w_mtimer_next;
      r_ctimer <= w_ctimer_next;
      r_mt     <= w_mt_next;
      r_dir    <= w_dir_next;
      r_al     <= w_al_next;
      r_tfl    <= w_tfl_next;
      r_fault  <= w_fault_next;
    end
  end

  assign MT       = r_mt;
  assign DIR      = r_dir;
  assign AL       = r_al;
  assign TFL      = r_tfl;
  assign Fault    = r_fault;
  assign CarCount = w_count;

endmodule

// File: tb/tb_drawbridge_ctrl.sv
// Directed testbench for drawbridge_ctrl (LANES=2, CNT_W=2, CLEAR_DELAY=4,
// MOTOR_TIMEOUT=10). Expected outputs are packed as
// {MT, DIR, AL, TFL, CarCount[1:0], Fault}.
module tb_drawbridge_ctrl;

  localparam int LANES = 2;
  localparam int CNT_W = 2;

  typedef struct {
    logic       rst_n;
    logic [1:0] ci;
    logic [1:0] co;
    logic       md, pb, bs, h, l;
    logic [6:0] exp;
  } vec_t;

  logic Clk, Reset, MD, PB, BS, H, L;
  logic [LANES-1:0] CarIn, CarOut;
  logic MT, DIR, AL, TFL, Fault;
  logic [CNT_W-1:0] CarCount;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vt[$];

  drawbridge_ctrl #(
    .LANES         (LANES),
    .CNT_W         (CNT_W),
    .CLEAR_DELAY   (4),
    .MOTOR_TIMEOUT (10)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .CarIn    (CarIn),
    .CarOut   (CarOut),
    .MD       (MD),
    .PB       (PB),
    .BS       (BS),
    .H        (H),
    .L        (L),
    .MT       (MT),
    .DIR      (DIR),
    .AL       (AL),
    .TFL      (TFL),
    .CarCount (CarCount),
    .Fault    (Fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [6:0] e(input logic mt, dir, al, tfl,
                                   input logic [1:0] cnt, input logic flt);
    return {mt, dir, al, tfl, cnt, flt};
  endfunction

  function automatic vec_t v(input logic rst_n, input logic [1:0] ci, co,
                             input logic md, pb, bs, h, l, input logic [6:0] ex);
    vec_t r;
    r.rst_n = rst_n; r.ci = ci; r.co = co;
    r.md = md; r.pb = pb; r.bs = bs; r.h = h; r.l = l;
    r.exp = ex;
    return r;
  endfunction

  task automatic drive(input logic rst_n, input logic [1:0] ci, co,
                       input logic md, pb, bs, h, l);
    Reset = rst_n; CarIn = ci; CarOut = co;
    MD = md; PB = pb; BS = bs; H = h; L = l;
  endtask

  // One edge, then sample 1 time unit later and compare.
  task automatic step_check(input string name, input logic [6:0] ex);
    logic [6:0] act;
    @(posedge Clk);
    #1;
    act = {MT, DIR, AL, TFL, CarCount, Fault};
    n_tests++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got mt,dir,al,tfl,cnt,flt=%b required %b", name, act, ex);
    end else begin
      $display("[TB] %s ok %b", name, act);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    step_check("reset", e(0, 0, 0, 0, 2'd0, 0));
  endtask

  // From FLAT with an empty deck: request held, four clearing edges,
  // fifth edge starts the motor upward.
  task automatic go_lifting(input logic md);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 2'b00, md, md, !md, 0, 1);
      step_check("clearing", e(0, 0, 0, 1, 2'd0, 0));
    end
    drive(1'b1, 2'b00, 2'b00, md, md, !md, 0, 1);
    step_check("enter_lift", e(1, 1, 0, 1, 2'd0, 0));
  endtask

  // Lifting with H held low: nine more running cycles, then fault.
  task automatic run_to_timeout(input string name);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 2'b00, 2'b00, 0, 0, 1, 0, 0);
      step_check({name, "_run"}, e(1, 1, 0, 1, 2'd0, 0));
    end
    drive(1'b1, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    step_check({name, "_fault"}, e(0, 0, 1, 1, 2'd0, 1));
  endtask

  initial begin
    drive(1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 1);

    // rst, ci, co, md, pb, bs, h, l, {mt,dir,al,tfl,cnt,flt}
    vt.push_back(v(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, e(0,0,0,0,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, e(0,0,0,0,2'd0,0)));
    // auto cycle
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 1, e(0,0,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 1, e(0,0,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 1, e(0,0,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 1, e(0,0,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 1, e(1,1,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 0, e(1,1,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 1, 0, e(0,0,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 1, 0, e(0,0,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 0, 1, 0, e(1,0,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, e(1,0,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, e(0,0,0,0,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, e(0,0,0,0,2'd0,0)));
    // deck occupancy holds CLEARING
    vt.push_back(v(1, 2'b11, 2'b00, 0, 0, 0, 0, 1, e(0,0,0,0,2'd2,0)));
    vt.push_back(v(1, 2'b00, 2'b01, 0, 0, 0, 0, 1, e(0,0,0,0,2'd1,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 1, e(0,0,0,1,2'd1,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 1, e(0,0,0,1,2'd1,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 1, e(0,0,0,1,2'd1,0)));
    vt.push_back(v(1, 2'b00, 2'b10, 0, 0, 1, 0, 1, e(0,0,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 1, e(0,0,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 1, e(0,0,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 1, e(0,0,0,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 1, e(1,1,0,1,2'd0,0)));
    // pause while lifting
    vt.push_back(v(1, 2'b01, 2'b00, 0, 0, 1, 0, 0, e(0,1,1,1,2'd1,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 0, e(0,1,1,1,2'd1,0)));
    vt.push_back(v(1, 2'b00, 2'b01, 0, 0, 1, 0, 0, e(0,1,1,1,2'd0,0)));
    vt.push_back(v(1, 2'b00, 2'b00, 0, 0, 1, 0, 0, e(1,1,0,1,2'd0,0)));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst_n, vt[i].ci, vt[i].co, vt[i].md, vt[i].pb,
            vt[i].bs, vt[i].h, vt[i].l);
      step_check($sformatf("vec%0d", i), vt[i].exp);
    end

    // Motor timer frozen during the pause: one running cycle before it,
    // so nine more after it reach the timeout (8 running, then fault).
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b00, 2'b00, 0, 0, 1, 0, 0);
      step_check("pause_timer_run", e(1, 1, 0, 1, 2'd0, 0));
    end
    drive(1'b1, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    step_check("pause_timer_fault", e(0, 0, 1, 1, 2'd0, 1));
    // Fault latches; counter keeps running inside it.
    drive(1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    step_check("fault_hold", e(0, 0, 1, 1, 2'd0, 1));
    drive(1'b1, 2'b01, 2'b00, 0, 0, 0, 0, 1);
    step_check("fault_count", e(0, 0, 1, 1, 2'd1, 1));
    do_reset();

    // Plain timeout from a fresh lift.
    go_lifting(1'b0);
    run_to_timeout("timeout");
    do_reset();

    // Reversal in LOWERING clears the motor timer.
    go_lifting(1'b0);
    drive(1'b1, 2'b00, 2'b00, 0, 0, 1, 1, 0);
    step_check("rev_upright", e(0, 0, 0, 1, 2'd0, 0));
    drive(1'b1, 2'b00, 2'b00, 0, 0, 0, 1, 0);
    step_check("rev_lowering", e(1, 0, 0, 1, 2'd0, 0));
    drive(1'b1, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    step_check("rev_lifting", e(1, 1, 0, 1, 2'd0, 0));
    run_to_timeout("rev_timeout");
    do_reset();

    // Manual mode, car activity in UPRIGHT, then mode switch.
    go_lifting(1'b1);
    drive(1'b1, 2'b00, 2'b00, 1, 1, 0, 1, 0);
    step_check("man_upright", e(0, 0, 0, 1, 2'd0, 0));
    drive(1'b1, 2'b01, 2'b01, 1, 1, 0, 1, 0);
    step_check("upright_activity", e(0, 0, 1, 1, 2'd0, 0));
    drive(1'b1, 2'b00, 2'b00, 1, 1, 0, 1, 0);
    step_check("upright_quiet", e(0, 0, 0, 1, 2'd0, 0));
    drive(1'b1, 2'b00, 2'b00, 0, 1, 0, 1, 0);
    step_check("mode_switch", e(1, 0, 0, 1, 2'd0, 0));
    do_reset();

    // Both limit switches, and missing L while FLAT.
    drive(1'b1, 2'b00, 2'b00, 0, 0, 0, 1, 1);
    step_check("h_and_l", e(0, 0, 1, 1, 2'd0, 1));
    do_reset();
    drive(1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    step_check("flat_no_l", e(0, 0, 1, 1, 2'd0, 1));
    do_reset();

    // Saturation at both ends.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 2'b01, 2'b00, 0, 0, 0, 0, 1);
      step_check("sat_count", e(0, 0, 0, 0, 2'(i), 0));
    end
    drive(1'b1, 2'b01, 2'b00, 0, 0, 0, 0, 1);
    step_check("sat_hi", e(0, 0, 1, 0, 2'd3, 0));
    drive(1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    step_check("sat_hi_pulse", e(0, 0, 0, 0, 2'd3, 0));
    drive(1'b1, 2'b01, 2'b01, 0, 0, 0, 0, 1);
    step_check("net_zero", e(0, 0, 0, 0, 2'd3, 0));
    drive(1'b1, 2'b00, 2'b11, 0, 0, 0, 0, 1);
    step_check("dec_two", e(0, 0, 0, 0, 2'd1, 0));
    drive(1'b1, 2'b00, 2'b11, 0, 0, 0, 0, 1);
    step_check("sat_lo_partial", e(0, 0, 1, 0, 2'd0, 0));
    drive(1'b1, 2'b00, 2'b01, 0, 0, 0, 0, 1);
    step_check("sat_lo", e(0, 0, 1, 0, 2'd0, 0));
    drive(1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    step_check("sat_lo_pulse", e(0, 0, 0, 0, 2'd0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/drawbridge_ctrl.md
# drawbridge_ctrl

Parametrised drawbridge controller: successor to the single-lane bridge FSM with car counter. Tracks vehicles on the deck across `LANES` lanes, gates the traffic light, drives a bidirectional deck motor between `Low`/`High` limit switches, and enforces a clear-deck delay, a motor timeout and a latched fault state. Sits between the sensor and button conditioning logic and the motor and light drivers.

## Interface
- `LANES`, 2: number of lanes, each with one entry and one exit sensor.
- `CNT_W`, 8: car counter width; saturates at 2^CNT_W-1.
- `CLEAR_DELAY`, 16: consecutive empty-deck cycles required before lifting (≥1).
- `MOTOR_TIMEOUT`, 1000: maximum motor-running cycles per travel before fault (≥2).

Ports:
- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `CarIn`  in  LANES  per-lane entry pulse, one cycle per car.
- `CarOut`  in  LANES  per-lane exit pulse, one cycle per car.
- `MD`  in  1  mode: 0 = auto (request = `BS`), 1 = manual (request = `PB`).
- `PB`  in  1  operator lift request, level.
- `BS`  in  1  boat sensor, level.
- `H`  in  1  deck-up limit switch.
- `L`  in  1  deck-down limit switch.
- `MT`  out  1  motor enable.
- `DIR`  out  1  motor direction: 1 = up, 0 = down.
- `AL`  out  1  alarm.
- `TFL`  out  1  traffic light: 1 = red, 0 = green.
- `CarCount`  out  CNT_W  vehicles currently on deck.
- `Fault`  out  1  latched fault.

## Operation
- Request `req` is `MD ? PB : BS`. It is re-evaluated every cycle, so a mode change takes effect immediately.
- Counter update per cycle: `CarCount += popcount(CarIn) − popcount(CarOut)`.
  - Computed in CNT_W+2 signed arithmetic.
  - Clamps at 0 and at 2^CNT_W-1.
  - An underflow or overflow clamp sets `AL` for one cycle.
- States are FLAT, CLEARING, LIFTING, UPRIGHT, LOWERING and FAULT.
- FLAT: `TFL`=0, `MT`=0.
  - `req`&`L` → CLEARING.
  - `L`=0 → FAULT.
- CLEARING: `TFL`=1, `MT`=0.
  - The clear timer counts cycles with `CarCount`==0 and no `CarIn` bit set. Any car activity zeroes it.
  - Timer == CLEAR_DELAY−1 → LIFTING.
  - `req`=0 → FLAT. This check has priority over the timer.
- LIFTING: `TFL`=1, `DIR`=1, `MT`=1 unless paused.
  - Pause: `CarCount`≠0 or any `CarIn` set gives `MT`=0 and `AL`=1, and freezes the motor timer.
  - `H` → UPRIGHT.
  - Motor timer == MOTOR_TIMEOUT → FAULT.
- UPRIGHT: `TFL`=1, `MT`=0.
  - `req`=0 → LOWERING.
  - `H`=0 → FAULT.
- LOWERING: `TFL`=1, `DIR`=0, same pause rule as LIFTING.
  - `L` → FLAT.
  - `req`=1 → LIFTING, with the motor timer cleared. This reverses for a late boat.
  - Timeout → FAULT.
- FAULT: `MT`=0, `TFL`=1, `AL`=1, `Fault`=1. Only `Reset` exits this state.
- `H`&`L` asserted together in any state → FAULT. This has the highest priority.
- Car activity in UPRIGHT sets `AL`=1. State is unchanged.
- The counter keeps running in every state, including FAULT.

## Timing
- All outputs are registered (Moore): a transition at edge n is visible on the outputs after edge n.
- Reset values:
  - State is FLAT.
  - `MT`=0, `DIR`=0, `AL`=0, `TFL`=0, `Fault`=0, `CarCount`=0.
  - Both timers are 0.
- Reset samples on the rising `Clk` edge only. Asserting it mid-travel stops the motor at the next edge.
- Inputs are sampled at the rising edge. Request to motor start is CLEAR_DELAY+1 cycles minimum.
- Limit switch to motor stop is 1 cycle.
- Motor timer width is $clog2(MOTOR_TIMEOUT+1). Clear timer width is $clog2(CLEAR_DELAY+1).
- Simultaneous `CarIn` and `CarOut` on the same lane net to zero.

## Structure
- Package `drawbridge_pkg`: state enum `bridge_state_t` and default constants for the four parameters.
- Sub-module `lane_car_counter`, parameterised by LANES and CNT_W: does the popcounts, the saturating counter and the clamp-alarm pulse.
- Top level: state machine, two timers, output register.

## Test plan
- Auto cycle (`MD`=0, CLEAR_DELAY=4): `BS`↑ with `L`=1 and empty deck.
  - `TFL`=1 next cycle, `MT`=1 & `DIR`=1 five cycles after `BS`.
  - `H`↑ → `MT`=0. `BS`↓ → `DIR`=0, `MT`=1. `L`↑ → `TFL`=0.
- Deck occupancy (LANES=2): `CarIn`=2'b11, then `CarOut`=2'b01.
  - `CarCount`=2, then 1.
  - `BS`↑ holds CLEARING until a further `CarOut` gives 0, then CLEAR_DELAY more cycles.
- Pause: `CarIn` pulse during LIFTING → `MT`=0 and `AL`=1 while `CarCount`=1. `CarOut` resumes the motor; the motor timer is unchanged.
- Timeout (MOTOR_TIMEOUT=10): LIFTING with `H` held 0 → `Fault`=1, `MT`=0 after 10 motor cycles. FAULT persists until `Reset`=0 at an edge restores all reset values.
- Reversal and mode switch:
  - In LOWERING, `BS`↑ → LIFTING.
  - In UPRIGHT (`MD`=1, `PB`=1), switching `MD`→0 with `BS`=0 → LOWERING next edge.
- Saturation: CNT_W=2 with 4 entry pulses → `CarCount`=3 and a one-cycle `AL`. A `CarOut` at count 0 stays 0 with a one-cycle `AL`.
